uart_mmio_responder: RTL and testbench
======================================

// Module: uart_mmio_responder
// PURPOSE
//  Responder side of the CPU's UART/counter MMIO window. Consumes the uart_read/uart_write
//  strobes produced by the core's address decoder, returns registered read data, drives the
//  ready/valid handshakes of the UART RX and TX FIFOs, and owns the cycle and retired-instruction
//  counters. Sits between the core's memory stage and the uart instance.
// PARAMETERS
//  ADDR_WIDTH  8   low MMIO address bits seen by the block
//  DATA_WIDTH  32  CPU data bus width
//  CNT_WIDTH   32  width of cycle and instruction counters; must be <= DATA_WIDTH
// PORTS
//  clk                 in   1           system clock, all state on rising edge
//  rst_n               in   1           asynchronous reset, active-low
//  uart_read           in   1           MMIO load strobe, one cycle per load
//  uart_write          in   1           MMIO store strobe, one cycle per store
//  addr                in   ADDR_WIDTH  MMIO register offset
//  wdata               in   DATA_WIDTH  store data
//  inst_retire         in   1           one instruction retired this cycle
//  rdata               out  DATA_WIDTH  registered load data
//  rx_data_out         in   8           UART RX byte
//  rx_data_out_valid   in   1           UART RX byte available
//  rx_data_out_ready   out  1           pop RX byte
//  tx_data_in          out  8           byte to UART TX
//  tx_data_in_valid    out  1           TX byte pending
//  tx_data_in_ready    in   1           UART TX can accept
// BEHAVIOUR
//  Reset (rst_n low, async): rdata=0, rx_data_out_ready=0, tx_data_in_valid=0, tx_data_in=0,
//   cycle_cnt=0, inst_cnt=0, tx_overrun=0. Deasserted synchronously by the reset generator.
//  Register map (offset): 0x00 ctrl R {29'b0, tx_overrun, rx_valid, tx_ready};
//   0x04 rx R {24'b0, rx_data_out}; 0x08 tx W wdata[7:0]; 0x10 cycle_cnt R; 0x14 inst_cnt R;
//   0x18 counter reset W (data ignored). Reads of other offsets return 0; writes ignored.
//  tx_ready bit = tx_data_in_ready & ~tx_data_in_valid; rx_valid bit = rx_data_out_valid.
//  Read latency: exactly 1 cycle; rdata updates on edge after uart_read, holds until next read.
//   Values sampled are pre-edge (counter read returns value before that cycle's increment).
//  RX pop: uart_read at 0x04 with rx_data_out_valid=1 -> rx_data_out_ready=1 for that one cycle
//   (combinational from strobe); rdata captures the byte. With rx valid=0: rdata=0, no pop.
//  TX FSM: IDLE -> PEND on uart_write@0x08 (tx_data_in <= wdata[7:0], tx_data_in_valid <= 1).
//   PEND -> IDLE on edge where tx_data_in_valid & tx_data_in_ready. tx_data_in stable in PEND.
//   Write @0x08 while PEND: byte dropped, tx_overrun <= 1 (sticky), PEND byte unchanged,
//   even if handshake completes that same edge.
//  tx_overrun clears on edge after a read of 0x00 (read returns 1); a new overrun in the
//   same cycle as that read wins (bit stays 1).
//  cycle_cnt += 1 every cycle; inst_cnt += 1 when inst_retire. Both wrap at 2^CNT_WIDTH to 0.
//   Write @0x18: both counters = 0 on next edge; clear beats simultaneous increment.
//  uart_read and uart_write in same cycle: both take effect independently (single addr; e.g.
//   0x18 write + 0x10 read returns pre-clear value).
//  Reset mid-transfer: pending TX byte discarded, tx_data_in_valid drops immediately.
// TESTING
//  Reset then read 0x10 after 5 idle cycles -> rdata=5 one cycle later; tx_valid=0.
//  Write 0x08 wdata=0x41, tx_ready=0 for 3 cycles then 1 -> tx_data_in=0x41 valid 4 cycles, one handshake.
//  rx_valid=1, rx_data=0x5A, read 0x04 -> rx_ready pulses 1 cycle, rdata=0x5A; rx_valid=0 -> rdata=0, no pulse.
//  Two writes 0x08 (0x11,0x22) back-to-back, tx_ready=0 -> 0x11 sent, ctrl read=0x4, next ctrl read=0x0.
//  Preload cycle_cnt=0xFFFFFFFF via force, 1 cycle -> 0; write 0x18 with inst_retire=1 -> inst_cnt=0.
//  Assert rst_n low during PEND -> tx_data_in_valid=0 asynchronously, counters 0, rdata 0.

Source files
------------

// File: rtl/uart_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mmio_responder
//  Purpose  : Responder for the CPU UART/counter MMIO window. Turns decoded
//             load/store strobes into registered read data, RX-pop and
//             TX-push handshakes, and owns the free-running cycle counter
//             and retired-instruction counter.
//  Ports    : clk, rst_n               - clock, asynchronous active-low reset
//             uart_read, uart_write    - one-cycle MMIO load/store strobes
//             addr, wdata              - MMIO offset and store data
//             inst_retire              - one instruction retired this cycle
//             rdata                    - registered load data (1-cycle latency)
//             rx_data_out/_valid/_ready - UART RX byte stream (we pop)
//             tx_data_in/_valid/_ready  - UART TX byte stream (we push)
//  Register map (byte offsets):
//             0x00 R ctrl {29'b0, tx_overrun, rx_valid, tx_ready}
//             0x04 R rx byte (pops the RX FIFO when a byte is present)
//             0x08 W tx byte
//             0x10 R cycle counter   0x14 R instruction counter
//             0x18 W clear both counters (data ignored)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_mmio_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_read,
  input  logic                  uart_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  inst_retire,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [7:0]            rx_data_out,
  input  logic                  rx_data_out_valid,
  output logic                  rx_data_out_ready,
  output logic [7:0]            tx_data_in,
  output logic                  tx_data_in_valid,
  input  logic                  tx_data_in_ready
);

  localparam logic [ADDR_WIDTH-1:0] C_ADDR_CTRL  = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_RX    = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_TX    = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_CYCLE = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_INST  = ADDR_WIDTH'(8'h14);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_CLR   = ADDR_WIDTH'(8'h18);

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_t;

  tx_state_t             r_tx_state;
  tx_state_t             w_tx_state_next;
  logic                  w_tx_load;
  logic                  w_overrun_set;
  logic                  r_tx_overrun;
  logic [CNT_WIDTH-1:0]  r_cycle_cnt;
  logic [CNT_WIDTH-1:0]  r_inst_cnt;
  logic [DATA_WIDTH-1:0] w_rd_mux;

  // Only the low byte of a store is meaningful to this block.
  logic w_unused;
  assign w_unused = &{1'b0, wdata[DATA_WIDTH-1:8]};

  // Strobe/address decode.
  logic w_rd_ctrl, w_rd_rx, w_wr_tx, w_wr_clr;
  assign w_rd_ctrl = uart_read  && (addr == C_ADDR_CTRL);
  assign w_rd_rx   = uart_read  && (addr == C_ADDR_RX);
  assign w_wr_tx   = uart_write && (addr == C_ADDR_TX);
  assign w_wr_clr  = uart_write && (addr == C_ADDR_CLR);

  // The pop is combinational so the FIFO advances on the same edge that
  // rdata captures the byte it is presenting.
  assign rx_data_out_ready = w_rd_rx && rx_data_out_valid;

  // Valid is the state bit itself, so it falls the instant reset asserts.
  assign tx_data_in_valid = (r_tx_state == TX_PEND);

  // ---------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      tx_data_in <= 8'h00;
    end else begin
      r_tx_state <= w_tx_state_next;
      if (w_tx_load) begin
        tx_data_in <= wdata[7:0];
      end
    end
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_load       = 1'b0;
    w_overrun_set   = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_wr_tx) begin
          w_tx_state_next = TX_PEND;
          w_tx_load       = 1'b1;
        end
      end
      TX_PEND: begin
        if (tx_data_in_ready) begin
          w_tx_state_next = TX_IDLE;
        end
        // A store while a byte is pending is dropped even if the pending
        // byte is accepted on this same edge; the FSM does not reload.
        if (w_wr_tx) begin
          w_overrun_set = 1'b1;
        end
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  // Sticky overrun flag: cleared by a ctrl read, but a fresh overrun wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_tx_overrun <= 1'b1;
    end else if (w_rd_ctrl) begin
      r_tx_overrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Counters (clear has priority over the increment of the same cycle)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else if (w_wr_clr) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
      r_inst_cnt  <= r_inst_cnt + CNT_WIDTH'(inst_retire);
    end
  end

  // ---------------------------------------------------------------------
  // Read path: all sources are sampled before the edge that loads rdata.
  // ---------------------------------------------------------------------
  always_comb begin
    w_rd_mux = '0;
    case (addr)
      C_ADDR_CTRL: w_rd_mux = DATA_WIDTH'({r_tx_overrun, rx_data_out_valid,
                                           tx_data_in_ready && !tx_data_in_valid});
      C_ADDR_RX: begin
        if (rx_data_out_valid) begin
          w_rd_mux = DATA_WIDTH'(rx_data_out);
        end
      end
      C_ADDR_CYCLE: w_rd_mux = DATA_WIDTH'(r_cycle_cnt);
      C_ADDR_INST:  w_rd_mux = DATA_WIDTH'(r_inst_cnt);
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (uart_read) begin
      rdata <= w_rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_mmio_responder
//  Purpose  : Directed self-checking bench for uart_mmio_responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mmio_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_read;
  logic        uart_write;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        inst_retire;
  logic [31:0] rdata;
  logic [7:0]  rx_data_out;
  logic        rx_data_out_valid;
  logic        rx_data_out_ready;
  logic [7:0]  tx_data_in;
  logic        tx_data_in_valid;
  logic        tx_data_in_ready;

  int checks   = 0;
  int failures = 0;

  uart_mmio_responder #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .CNT_WIDTH (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .uart_read        (uart_read),
    .uart_write       (uart_write),
    .addr             (addr),
    .wdata            (wdata),
    .inst_retire      (inst_retire),
    .rdata            (rdata),
    .rx_data_out      (rx_data_out),
    .rx_data_out_valid(rx_data_out_valid),
    .rx_data_out_ready(rx_data_out_ready),
    .tx_data_in       (tx_data_in),
    .tx_data_in_valid (tx_data_in_valid),
    .tx_data_in_ready (tx_data_in_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; uart_read = 1'b0; uart_write = 1'b0; addr = 8'h00;
    wdata = 32'h0; inst_retire = 1'b0; rx_data_out = 8'h00;
    rx_data_out_valid = 1'b0; tx_data_in_ready = 1'b0;
    tick(); tick();
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    checks++; if (tx_data_in_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_data_in_valid); end
    checks++; if (tx_data_in !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data_in); end
    checks++; if (rx_data_out_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%b exp=0", rx_data_out_ready); end
    rst_n = 1'b1;
    repeat (5) tick();
    uart_read = 1'b1; addr = 8'h10;
    tick();
    uart_read = 1'b0;
    checks++; if (rdata !== 32'd5) begin failures++; $display("FAIL cycle_after_5 got=%0d exp=5", rdata); end
    checks++; if (tx_data_in_valid !== 1'b0) begin failures++; $display("FAIL idle_tx_valid got=%b exp=0", tx_data_in_valid); end
    tick();
    checks++; if (rdata !== 32'd5) begin failures++; $display("FAIL rdata_hold got=%0d exp=5", rdata); end
  endtask

  task automatic test_tx_handshake();
    int valid_cycles = 0;
    int handshakes   = 0;
    tx_data_in_ready = 1'b0;
    uart_write = 1'b1; addr = 8'h08; wdata = 32'hDEAD_BE41;
    tick();
    uart_write = 1'b0; wdata = 32'h0;
    for (int i = 0; i < 8; i++) begin
      tx_data_in_ready = (i >= 3);
      #1;
      if (tx_data_in_valid) begin
        valid_cycles++;
        checks++; if (tx_data_in !== 8'h41) begin failures++; $display("FAIL tx_data_stable cyc=%0d got=%h exp=41", i, tx_data_in); end
        if (tx_data_in_ready) handshakes++;
      end
      tick();
    end
    checks++; if (valid_cycles !== 4) begin failures++; $display("FAIL tx_valid_cycles got=%0d exp=4", valid_cycles); end
    checks++; if (handshakes !== 1) begin failures++; $display("FAIL tx_handshakes got=%0d exp=1", handshakes); end
    // Idle with TX ready: ctrl reports only tx_ready.
    uart_read = 1'b1; addr = 8'h00;
    tick();
    uart_read = 1'b0;
    checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL ctrl_idle got=%h exp=1", rdata); end
  endtask

  task automatic test_rx();
    rx_data_out_valid = 1'b1; rx_data_out = 8'h5A;
    uart_read = 1'b1; addr = 8'h04;
    #1;
    checks++; if (rx_data_out_ready !== 1'b1) begin failures++; $display("FAIL rx_pop_pulse got=%b exp=1", rx_data_out_ready); end
    tick();
    uart_read = 1'b0;
    #1;
    checks++; if (rdata !== 32'h5A) begin failures++; $display("FAIL rx_rdata got=%h exp=5a", rdata); end
    checks++; if (rx_data_out_ready !== 1'b0) begin failures++; $display("FAIL rx_pop_one_cycle got=%b exp=0", rx_data_out_ready); end
    // ctrl with rx byte present and TX idle/ready
    uart_read = 1'b1; addr = 8'h00;
    tick();
    uart_read = 1'b0;
    checks++; if (rdata !== 32'h3) begin failures++; $display("FAIL ctrl_rx_tx got=%h exp=3", rdata); end
    rx_data_out_valid = 1'b0;
    uart_read = 1'b1; addr = 8'h04;
    #1;
    checks++; if (rx_data_out_ready !== 1'b0) begin failures++; $display("FAIL rx_empty_no_pop got=%b exp=0", rx_data_out_ready); end
    tick();
    uart_read = 1'b0;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rx_empty_rdata got=%h exp=0", rdata); end
    tx_data_in_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    tx_data_in_ready = 1'b0;
    uart_write = 1'b1; addr = 8'h08; wdata = 32'h11;
    tick();
    wdata = 32'h22;
    tick();
    uart_write = 1'b0;
    checks++; if (tx_data_in !== 8'h11) begin failures++; $display("FAIL b2b_keep_first got=%h exp=11", tx_data_in); end
    checks++; if (tx_data_in_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", tx_data_in_valid); end
    uart_read = 1'b1; addr = 8'h00;
    tick();
    checks++; if (rdata !== 32'h4) begin failures++; $display("FAIL ctrl_overrun got=%h exp=4", rdata); end
    tick();
    uart_read = 1'b0;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL ctrl_overrun_cleared got=%h exp=0", rdata); end
    // Store lands on the same edge the pending byte is accepted: still dropped.
    tx_data_in_ready = 1'b1;
    uart_write = 1'b1; addr = 8'h08; wdata = 32'h33;
    tick();
    uart_write = 1'b0;
    checks++; if (tx_data_in_valid !== 1'b0) begin failures++; $display("FAIL drop_on_handshake_valid got=%b exp=0", tx_data_in_valid); end
    uart_read = 1'b1; addr = 8'h00;
    tick();
    uart_read = 1'b0;
    checks++; if (rdata !== 32'h5) begin failures++; $display("FAIL ctrl_overrun_on_hs got=%h exp=5", rdata); end
    tx_data_in_ready = 1'b0;
  endtask

  task automatic test_counters();
    force dut.r_cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle_cnt;
    uart_read = 1'b1; addr = 8'h10;
    tick();
    checks++; if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cycle_preload got=%h exp=ffffffff", rdata); end
    tick();
    uart_read = 1'b0;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL cycle_wrap got=%h exp=0", rdata); end
    inst_retire = 1'b1;
    repeat (2) tick();
    uart_write = 1'b1; addr = 8'h18; wdata = 32'hFFFF_FFFF;
    tick();
    uart_write = 1'b0; inst_retire = 1'b0;
    uart_read = 1'b1; addr = 8'h10;
    tick();
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL cycle_cleared got=%h exp=0", rdata); end
    addr = 8'h14;
    tick();
    uart_read = 1'b0;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL inst_clear_beats_inc got=%h exp=0", rdata); end
    inst_retire = 1'b1;
    repeat (3) tick();
    inst_retire = 1'b0;
    uart_read = 1'b1; addr = 8'h14;
    tick();
    checks++; if (rdata !== 32'd3) begin failures++; $display("FAIL inst_count got=%0d exp=3", rdata); end
    addr = 8'h20;
    tick();
    uart_read = 1'b0;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", rdata); end
  endtask

  task automatic test_reset_mid_transfer();
    uart_read = 1'b1; addr = 8'h10;
    tick();
    uart_read = 1'b0;
    tx_data_in_ready = 1'b0;
    uart_write = 1'b1; addr = 8'h08; wdata = 32'h77;
    tick();
    uart_write = 1'b0;
    checks++; if (tx_data_in_valid !== 1'b1) begin failures++; $display("FAIL pend_before_reset got=%b exp=1", tx_data_in_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_data_in_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", tx_data_in_valid); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL async_reset_rdata got=%h exp=0", rdata); end
    checks++; if (dut.r_cycle_cnt !== 32'h0) begin failures++; $display("FAIL async_reset_cycle got=%h exp=0", dut.r_cycle_cnt); end
    checks++; if (dut.r_inst_cnt !== 32'h0) begin failures++; $display("FAIL async_reset_inst got=%h exp=0", dut.r_inst_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (tx_data_in_valid !== 1'b0) begin failures++; $display("FAIL byte_discarded got=%b exp=0", tx_data_in_valid); end
  endtask

  initial begin
    test_reset();
    test_tx_handshake();
    test_rx();
    test_back_to_back();
    test_counters();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
